// File: rtl/hbuf_pg_ring_if.sv
// Commit/clear/config bundle between the page writer, software clear path and the page ring.
interface hbuf_pg_ring_if #(
  parameter int PG_W   = 16,
  parameter int ADDR_W = 28,
  parameter int DROP_W = 16
);
  logic              en;
  logic [PG_W-1:0]   start_pg;
  logic [PG_W-1:0]   stop_pg;
  logic [PG_W-1:0]   afull_thresh;
  logic [PG_W-1:0]   first_pg;
  logic [PG_W-1:0]   last_pg;
  logic              cfg_err;
  logic              wr_commit;
  logic [PG_W-1:0]   wr_pg_num;
  logic [ADDR_W-1:0] wr_pg_addr;
  logic              commit_rej;
  logic [PG_W-1:0]   rd_pg_num;
  logic [PG_W-1:0]   n_used_pgs;
  logic              empty;
  logic              full;
  logic              afull;
  logic [PG_W-1:0]   clr_cnt;
  logic              clr_req;
  logic              clr_ack;
  logic [DROP_W-1:0] n_dropped;

  modport master (
    output en, start_pg, stop_pg, afull_thresh, wr_commit, clr_cnt, clr_req,
    input  first_pg, last_pg, cfg_err, wr_pg_num, wr_pg_addr, commit_rej,
           rd_pg_num, n_used_pgs, empty, full, afull, clr_ack, n_dropped
  );

  modport slave (
    input  en, start_pg, stop_pg, afull_thresh, wr_commit, clr_cnt, clr_req,
    output first_pg, last_pg, cfg_err, wr_pg_num, wr_pg_addr, commit_rej,
           rd_pg_num, n_used_pgs, empty, full, afull, clr_ack, n_dropped
  );
endinterface

// File: rtl/hbuf_pg_ring.sv
// DDR3 page-ring bookkeeper: read/write page pointers, explicit occupancy, flags,
// 4-phase clear handshake and optional overwrite-oldest with a saturating drop count.
module hbuf_pg_ring #(
  parameter int PG_W      = 16,
  parameter int ADDR_W    = 28,
  parameter int PG_SHIFT  = 12,
  parameter int OVERWRITE = 0,
  parameter int DROP_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  hbuf_pg_ring_if.slave bus
);
  localparam int CW = PG_W + 1;

  typedef enum logic [2:0] {S_OFF, S_INIT, S_RUN, S_FULL, S_ERR} state_t;

  state_t            state;
  logic [PG_W-1:0]   first_pg, last_pg, rd_pg, wr_pg;
  logic [CW-1:0]     n_alloc, n_used;
  logic              empty, full, afull, cfg_err, clr_ack, clr_req_q, commit_rej;
  logic [DROP_W-1:0] n_dropped;

  logic              clr_edge, is_full, do_commit, drop;
  logic [CW-1:0]     cnt_x, clr_k, used_nx;
  logic [PG_W-1:0]   rd_nx, wr_nx;

  // Advance p by k pages around [first_pg, last_pg]; k never exceeds n_alloc.
  function automatic logic [PG_W-1:0] adv(input logic [PG_W-1:0] p, input logic [CW-1:0] k,
                                          input logic [PG_W-1:0] stop, input logic [CW-1:0] alloc);
    logic [CW-1:0] s;
    s = {1'b0, p} + k;
    if (s > {1'b0, stop}) s = s - alloc;
    return s[PG_W-1:0];
  endfunction

  always_comb begin
    clr_edge  = bus.clr_req && !clr_req_q && !clr_ack;
    cnt_x     = {1'b0, bus.clr_cnt};
    clr_k     = '0;
    if (clr_edge) clr_k = (cnt_x < n_used) ? cnt_x : n_used;
    is_full   = (state == S_FULL);
    do_commit = bus.wr_commit && (!is_full || OVERWRITE != 0);
    drop      = do_commit && is_full;
    wr_nx     = do_commit ? adv(wr_pg, CW'(1), last_pg, n_alloc) : wr_pg;
    rd_nx     = adv(rd_pg, clr_k, last_pg, n_alloc);
    used_nx   = n_used + {{PG_W{1'b0}}, do_commit} - clr_k;
    // Overwrite while full: the oldest page goes too, occupancy stays at n_alloc - k.
    if (drop) begin
      rd_nx   = adv(rd_nx, CW'(1), last_pg, n_alloc);
      used_nx = n_used - clr_k;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_OFF;  first_pg <= '0; last_pg <= '0; n_alloc <= '0;
      rd_pg <= '0;     wr_pg <= '0;    n_used <= '0;
      empty <= 1'b1;   full <= 1'b0;   afull <= 1'b0; cfg_err <= 1'b0;
      clr_ack <= 1'b0; clr_req_q <= 1'b0; commit_rej <= 1'b0; n_dropped <= '0;
    end else if (!bus.en) begin
      state <= S_OFF;  first_pg <= '0; last_pg <= '0; n_alloc <= '0;
      rd_pg <= '0;     wr_pg <= '0;    n_used <= '0;
      empty <= 1'b1;   full <= 1'b0;   afull <= 1'b0; cfg_err <= 1'b0;
      clr_ack <= 1'b0; clr_req_q <= 1'b0; commit_rej <= 1'b0; n_dropped <= '0;
    end else begin
      commit_rej <= 1'b0;
      // clr_req_q stays low in S_OFF so a request held across enable counts as a fresh edge.
      if (state != S_OFF) begin
        clr_req_q <= bus.clr_req;
        if (clr_edge)         clr_ack <= 1'b1;
        else if (!bus.clr_req) clr_ack <= 1'b0;
      end
      case (state)
        S_OFF: begin
          first_pg <= bus.start_pg;
          last_pg  <= bus.stop_pg;
          n_alloc  <= {1'b0, bus.stop_pg} - {1'b0, bus.start_pg} + CW'(1);
          state    <= S_INIT;
        end
        S_INIT: begin
          if (last_pg < first_pg) begin
            cfg_err <= 1'b1;
            state   <= S_ERR;
          end else begin
            rd_pg  <= first_pg;
            wr_pg  <= first_pg;
            n_used <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            afull  <= (bus.afull_thresh == '0);
            state  <= S_RUN;
          end
        end
        S_RUN, S_FULL: begin
          rd_pg      <= rd_nx;
          wr_pg      <= wr_nx;
          n_used     <= used_nx;
          empty      <= (used_nx == '0);
          full       <= (used_nx == n_alloc);
          afull      <= (used_nx >= {1'b0, bus.afull_thresh});
          commit_rej <= bus.wr_commit && is_full && (OVERWRITE == 0);
          if (drop && n_dropped != '1) n_dropped <= n_dropped + DROP_W'(1);
          state      <= (used_nx == n_alloc) ? S_FULL : S_RUN;
        end
        default: ;
      endcase
    end
  end

  assign bus.first_pg   = first_pg;
  assign bus.last_pg    = last_pg;
  assign bus.cfg_err    = cfg_err;
  assign bus.wr_pg_num  = wr_pg;
  assign bus.wr_pg_addr = ADDR_W'({{ADDR_W{1'b0}}, wr_pg} << PG_SHIFT);
  assign bus.commit_rej = commit_rej;
  assign bus.rd_pg_num  = rd_pg;
  assign bus.n_used_pgs = n_used[PG_W-1:0];
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.afull      = afull;
  assign bus.clr_ack    = clr_ack;
  assign bus.n_dropped  = n_dropped;
endmodule

// File: tb/tb_hbuf_pg_ring.sv
// Directed bench: two rings (refuse-when-full and overwrite-oldest) driven by the same stimulus.
module tb_hbuf_pg_ring;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en = 1'b0, wr_commit = 1'b0, clr_req = 1'b0;
  logic [15:0] start_pg = '0, stop_pg = '0, afull_thresh = 16'd3, clr_cnt = '0;
  int checks = 0, failures = 0;

  hbuf_pg_ring_if #(.PG_W(16), .ADDR_W(28), .DROP_W(16)) i0 ();
  hbuf_pg_ring_if #(.PG_W(16), .ADDR_W(28), .DROP_W(16)) i1 ();

  assign i0.en = en;           assign i1.en = en;
  assign i0.start_pg = start_pg; assign i1.start_pg = start_pg;
  assign i0.stop_pg = stop_pg;   assign i1.stop_pg = stop_pg;
  assign i0.afull_thresh = afull_thresh; assign i1.afull_thresh = afull_thresh;
  assign i0.wr_commit = wr_commit; assign i1.wr_commit = wr_commit;
  assign i0.clr_cnt = clr_cnt;   assign i1.clr_cnt = clr_cnt;
  assign i0.clr_req = clr_req;   assign i1.clr_req = clr_req;

  hbuf_pg_ring #(.PG_W(16), .ADDR_W(28), .PG_SHIFT(12), .OVERWRITE(0), .DROP_W(16))
    d0 (.clk(clk), .rst(rst), .bus(i0));
  hbuf_pg_ring #(.PG_W(16), .ADDR_W(28), .PG_SHIFT(12), .OVERWRITE(1), .DROP_W(16))
    d1 (.clk(clk), .rst(rst), .bus(i1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit();
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #12;
    chk("rst_empty", 32'(i0.empty), 32'd1);
    chk("rst_full", 32'(i0.full), 32'd0);
    chk("rst_afull", 32'(i0.afull), 32'd0);
    chk("rst_wr", 32'(i0.wr_pg_num), 32'd0);
    chk("rst_ack", 32'(i0.clr_ack), 32'd0);
    chk("rst_drop", 32'(i1.n_dropped), 32'd0);
    rst = 1'b0;

    start_pg = 16'd4; stop_pg = 16'd7; en = 1'b1;
    tick(); tick();
    chk("first_pg", 32'(i0.first_pg), 32'd4);
    chk("last_pg", 32'(i0.last_pg), 32'd7);
    chk("init_wr", 32'(i0.wr_pg_num), 32'd4);
    chk("init_rd", 32'(i0.rd_pg_num), 32'd4);
    chk("init_empty", 32'(i0.empty), 32'd1);

    commit();
    chk("c1_wr", 32'(i0.wr_pg_num), 32'd5);
    chk("c1_addr", 32'(i0.wr_pg_addr), 32'h5000);
    chk("c1_used", 32'(i0.n_used_pgs), 32'd1);
    commit();
    chk("c2_wr", 32'(i0.wr_pg_num), 32'd6);
    chk("c2_afull", 32'(i0.afull), 32'd0);
    commit();
    chk("c3_wr", 32'(i0.wr_pg_num), 32'd7);
    chk("c3_afull", 32'(i0.afull), 32'd1);
    commit();
    chk("c4_wr_wrap", 32'(i0.wr_pg_num), 32'd4);
    chk("c4_used", 32'(i0.n_used_pgs), 32'd4);
    chk("c4_full", 32'(i0.full), 32'd1);

    commit();
    chk("c5_rej", 32'(i0.commit_rej), 32'd1);
    chk("c5_wr", 32'(i0.wr_pg_num), 32'd4);
    chk("c5_rd", 32'(i0.rd_pg_num), 32'd4);
    chk("ow1_rd", 32'(i1.rd_pg_num), 32'd5);
    chk("ow1_drop", 32'(i1.n_dropped), 32'd1);
    tick();
    chk("rej_pulse", 32'(i0.commit_rej), 32'd0);
    commit();
    chk("ow2_rd", 32'(i1.rd_pg_num), 32'd6);
    chk("ow2_wr", 32'(i1.wr_pg_num), 32'd6);
    chk("ow2_used", 32'(i1.n_used_pgs), 32'd4);
    chk("ow2_drop", 32'(i1.n_dropped), 32'd2);

    clr_cnt = 16'd2; clr_req = 1'b1;
    tick();
    chk("clr2_ack", 32'(i0.clr_ack), 32'd1);
    chk("clr2_rd", 32'(i0.rd_pg_num), 32'd6);
    chk("clr2_used", 32'(i0.n_used_pgs), 32'd2);
    chk("clr2_full", 32'(i0.full), 32'd0);
    chk("clr2_ow_rd", 32'(i1.rd_pg_num), 32'd4);
    tick();
    chk("clr2_hold_ack", 32'(i0.clr_ack), 32'd1);
    chk("clr2_hold_rd", 32'(i0.rd_pg_num), 32'd6);
    clr_req = 1'b0;
    tick();
    chk("clr2_ack_low", 32'(i0.clr_ack), 32'd0);

    commit();
    chk("c6_wr", 32'(i0.wr_pg_num), 32'd5);
    chk("c6_used", 32'(i0.n_used_pgs), 32'd3);

    clr_cnt = 16'd9; clr_req = 1'b1;
    tick();
    chk("clip_rd", 32'(i0.rd_pg_num), 32'd5);
    chk("clip_empty", 32'(i0.empty), 32'd1);
    chk("clip_ow_rd", 32'(i1.rd_pg_num), 32'd7);
    clr_req = 1'b0;
    tick();

    for (int n = 0; n < 4; n++) commit();
    chk("refill_full", 32'(i0.full), 32'd1);
    chk("refill_wr", 32'(i0.wr_pg_num), 32'd5);
    chk("refill_ow_wr", 32'(i1.wr_pg_num), 32'd7);
    clr_cnt = 16'd4; clr_req = 1'b1;
    tick();
    chk("fclr_empty", 32'(i0.empty), 32'd1);
    chk("fclr_full", 32'(i0.full), 32'd0);
    chk("fclr_rd", 32'(i0.rd_pg_num), 32'd5);
    chk("fclr_wr", 32'(i0.wr_pg_num), 32'd5);
    clr_req = 1'b0;
    tick();
    commit();
    chk("fclr_c_used", 32'(i0.n_used_pgs), 32'd1);

    commit();
    chk("pre_cc_afull", 32'(i0.afull), 32'd0);
    afull_thresh = 16'd1; clr_cnt = 16'd2; clr_req = 1'b1; wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
    chk("cc_used", 32'(i0.n_used_pgs), 32'd1);
    chk("cc_afull", 32'(i0.afull), 32'd1);
    chk("cc_wr", 32'(i0.wr_pg_num), 32'd4);
    chk("cc_rd", 32'(i0.rd_pg_num), 32'd7);
    chk("cc_ow_rd", 32'(i1.rd_pg_num), 32'd5);
    clr_req = 1'b0;
    tick();

    for (int n = 0; n < 3; n++) commit();
    clr_cnt = 16'd1; clr_req = 1'b1; wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
    chk("fcc_rej", 32'(i0.commit_rej), 32'd1);
    chk("fcc_used", 32'(i0.n_used_pgs), 32'd3);
    chk("fcc_rd", 32'(i0.rd_pg_num), 32'd4);
    chk("fcc_ow_rd", 32'(i1.rd_pg_num), 32'd7);
    chk("fcc_ow_wr", 32'(i1.wr_pg_num), 32'd6);
    chk("fcc_ow_used", 32'(i1.n_used_pgs), 32'd3);
    chk("fcc_ow_drop", 32'(i1.n_dropped), 32'd3);
    clr_req = 1'b0;
    tick();

    en = 1'b0;
    tick();
    chk("off_drop", 32'(i1.n_dropped), 32'd0);
    chk("off_used", 32'(i0.n_used_pgs), 32'd0);
    chk("off_first", 32'(i0.first_pg), 32'd0);

    start_pg = 16'd9; stop_pg = 16'd3; en = 1'b1;
    tick(); tick();
    chk("err_cfg", 32'(i0.cfg_err), 32'd1);
    commit();
    chk("err_wr", 32'(i0.wr_pg_num), 32'd0);
    chk("err_used", 32'(i0.n_used_pgs), 32'd0);
    clr_req = 1'b1;
    tick();
    chk("err_ack", 32'(i0.clr_ack), 32'd1);
    clr_req = 1'b0;
    tick();
    chk("err_ack_low", 32'(i0.clr_ack), 32'd0);
    en = 1'b0;
    tick();
    chk("err_clear", 32'(i0.cfg_err), 32'd0);

    start_pg = 16'd4; stop_pg = 16'd7; en = 1'b1;
    tick(); tick();
    commit();
    chk("re_addr", 32'(i0.wr_pg_addr), 32'h5000);
    clr_req = 1'b1;
    tick();
    chk("pre_rst_ack", 32'(i0.clr_ack), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ack", 32'(i0.clr_ack), 32'd0);
    chk("rst_mid_wr", 32'(i0.wr_pg_num), 32'd0);
    rst = 1'b0;
    tick(); tick();
    chk("held_req_ack", 32'(i0.clr_ack), 32'd1);
    clr_req = 1'b0;
    tick();
    chk("held_req_ack_low", 32'(i0.clr_ack), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
